// File: rtl/dsp_pkg.sv
// Shared DSP definitions used by the FIR stage and the decimating FIFO.
// Holds the sample width and the signed sample type, so every stage agrees
// on the data format.
package dsp_pkg;

   localparam int SAMPLE_W = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO that stores decimated samples.
// It owns the storage array, the read/write pointers, the occupancy count
// and the full/empty status. A push is accepted while the FIFO is full only
// if a pop happens in the same cycle. clear_i empties the FIFO at the next
// edge and overrides any push or pop in that cycle. The storage array is not
// reset, because its contents are never visible while the FIFO is empty.
module sync_fifo
   import dsp_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  sample_t          wrData_i,
   output sample_t          rdData_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   sample_t          mem [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush;
   logic             doPop;

   assign full_o   = (count_q == CNT_W'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign doPop    = pop_i && !empty_o;
   assign doPush   = push_i && (!full_o || doPop);
   assign rdData_o = mem[rdPtr_q];
   assign count_o  = count_q;

   // Next-state pointers and count; a clear wins over push and pop, and
   // pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (clear_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
         if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
         case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers, cleared immediately by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Sample storage, written at the write pointer whenever a push is accepted.
   always_ff @(posedge clock) begin
      if (doPush && !clear_i) mem[wrPtr_q] <= wrData_i;
   end

endmodule

// File: rtl/fir_decimator_fifo.sv
// Decimating output buffer for the FIR stage. It keeps one of every DECIM
// valid samples and queues the kept samples in a first-word-fall-through
// FIFO for a downstream consumer that uses a ready handshake. When a kept
// sample arrives while the FIFO is full and nothing is popped in the same
// cycle, that sample is dropped and a sticky overflow flag is raised.
// reset_n is active high despite its name.
// Optional macro FIR_DECIM_OVF_COUNT_EN adds an 8-bit count of dropped
// samples that saturates at 255.
module fir_decimator_fifo
   import dsp_pkg::*;
#(
   parameter int DECIM = 4,
   parameter int DEPTH = 16
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic                       sample_valid,
   input  logic                       flush,
   output logic signed [SAMPLE_W-1:0] out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       overflow
`ifdef FIR_DECIM_OVF_COUNT_EN
   ,
   output logic [7:0]                 overflow_cnt
`endif
);

   localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);

   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               overflow_q, overflow_d;
   logic               keep;
   logic               pop;
   logic               drop;
   logic               fifoFull;
   logic               fifoEmpty;

   assign keep      = sample_valid && (phase_q == PHASE_LAST);
   assign pop       = out_valid && out_ready;
   assign drop      = keep && fifoFull && !pop;
   assign out_valid = !fifoEmpty;
   assign overflow  = overflow_q;

   sync_fifo #(
      .DEPTH(DEPTH)
   ) uFifo (
      .clock    (clock),
      .reset    (reset_n),
      .clear_i  (flush),
      .push_i   (keep && !drop),
      .pop_i    (pop),
      .wrData_i (sample_in),
      .rdData_o (out_data),
      .count_o  (fifo_count),
      .full_o   (fifoFull),
      .empty_o  (fifoEmpty)
   );

   // The phase advances only on valid samples and wraps after the kept one;
   // a drop makes the overflow flag sticky until flush or reset.
   always_comb begin
      phase_d    = phase_q;
      overflow_d = overflow_q;
      if (flush) begin
         phase_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (sample_valid) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
         end
         if (drop) overflow_d = 1'b1;
      end
   end

   // Phase and overflow registers, cleared immediately by reset.
   always_ff @(posedge clock or posedge reset_n) begin
      if (reset_n) begin
         phase_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef FIR_DECIM_OVF_COUNT_EN
   logic [7:0] ovfCnt_q, ovfCnt_d;

   assign overflow_cnt = ovfCnt_q;

   // Count dropped samples and hold the count at 255 instead of wrapping.
   always_comb begin
      ovfCnt_d = ovfCnt_q;
      if (flush) begin
         ovfCnt_d = '0;
      end else if (drop && (ovfCnt_q != 8'hFF)) begin
         ovfCnt_d = ovfCnt_q + 8'd1;
      end
   end

   // Dropped-sample counter register, cleared immediately by reset.
   always_ff @(posedge clock or posedge reset_n) begin
      if (reset_n) ovfCnt_q <= '0;
      else         ovfCnt_q <= ovfCnt_d;
   end
`endif

endmodule

// File: tb/tb_fir_decimator_fifo.sv
// Directed testbench for fir_decimator_fifo. Instance A uses DECIM=4 and
// instance B uses DECIM=1; both have DEPTH=16. Inputs change on the falling
// clock edge and outputs are checked there, half a cycle after the rising
// edge that updated them.
module tb_fir_decimator_fifo;
   import dsp_pkg::*;

   logic    clock = 1'b0;
   int      total = 0;
   int      bad   = 0;

   logic    resetA, validA, flushA, readyA;
   sample_t sampleA, outDataA;
   logic    outValidA, ovfA;
   logic [4:0] countA;

   logic    resetB, validB, flushB, readyB;
   sample_t sampleB, outDataB;
   logic    outValidB, ovfB;
   logic [4:0] countB;

`ifdef FIR_DECIM_OVF_COUNT_EN
   logic [7:0] ovfCntA, ovfCntB;
`endif

   always #5 clock = ~clock;

   fir_decimator_fifo #(.DECIM(4), .DEPTH(16)) dutA (
      .clock        (clock),
      .reset_n      (resetA),
      .sample_in    (sampleA),
      .sample_valid (validA),
      .flush        (flushA),
      .out_data     (outDataA),
      .out_valid    (outValidA),
      .out_ready    (readyA),
      .fifo_count   (countA),
      .overflow     (ovfA)
`ifdef FIR_DECIM_OVF_COUNT_EN
      ,
      .overflow_cnt (ovfCntA)
`endif
   );

   fir_decimator_fifo #(.DECIM(1), .DEPTH(16)) dutB (
      .clock        (clock),
      .reset_n      (resetB),
      .sample_in    (sampleB),
      .sample_valid (validB),
      .flush        (flushB),
      .out_data     (outDataB),
      .out_valid    (outValidB),
      .out_ready    (readyB),
      .fifo_count   (countB),
      .overflow     (ovfB)
`ifdef FIR_DECIM_OVF_COUNT_EN
      ,
      .overflow_cnt (ovfCntB)
`endif
   );

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs on instance A.
   task automatic applyStimulus(input logic v, input int d, input logic rdy,
                                input logic fl);
      validA  = v;
      sampleA = sample_t'(d);
      readyA  = rdy;
      flushA  = fl;
   endtask

   initial begin
      resetA = 1'b1; resetB = 1'b1;
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      validB = 1'b0; sampleB = '0; readyB = 1'b0; flushB = 1'b0;

      // Reset state
      @(negedge clock);
      checkOutput("rst_validA", outValidA, 0);
      checkOutput("rst_countA", countA, 0);
      checkOutput("rst_ovfA",   ovfA, 0);
      checkOutput("rst_validB", outValidB, 0);
      checkOutput("rst_countB", countB, 0);
      resetA = 1'b0; resetB = 1'b0;

      // DECIM=4, inputs 1..16 back to back, consumer always ready
      for (int i = 1; i <= 17; i++) begin
         if (i > 1) begin
            checkOutput("dec4_valid", outValidA, ((i - 1) % 4 == 0) ? 1 : 0);
            if ((i - 1) % 4 == 0) checkOutput("dec4_data", outDataA, i - 1);
         end
         applyStimulus(i <= 16, (i <= 16) ? i : 0, 1'b1, 1'b0);
         @(negedge clock);
      end
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      checkOutput("dec4_drained", countA, 0);

      // Gapped valid: one valid sample every three cycles
      for (int j = 1; j <= 8; j++) begin
         applyStimulus(1'b1, 100 + j, 1'b0, 1'b0);
         @(negedge clock);
         applyStimulus(1'b0, 0, 1'b0, 1'b0);
         @(negedge clock);
         @(negedge clock);
      end
      checkOutput("gap_count", countA, 2);
      checkOutput("gap_valid", outValidA, 1);
      checkOutput("gap_head",  outDataA, 104);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("gap_head2",  outDataA, 108);
      checkOutput("gap_count2", countA, 1);
      @(negedge clock);
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      checkOutput("gap_empty", outValidA, 0);

      // Asynchronous reset with five samples stored and phase 2
      for (int k = 1; k <= 22; k++) begin
         applyStimulus(1'b1, 200 + k, 1'b0, 1'b0);
         @(negedge clock);
      end
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      checkOutput("pre_rst_count", countA, 5);
      checkOutput("pre_rst_head",  outDataA, 204);
      #2 resetA = 1'b1;
      #1;
      checkOutput("async_rst_valid", outValidA, 0);
      checkOutput("async_rst_count", countA, 0);
      @(negedge clock);
      resetA = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, 300 + k, 1'b1, 1'b0);
         @(negedge clock);
         checkOutput("post_rst_valid", outValidA, (k == 4) ? 1 : 0);
      end
      checkOutput("post_rst_data", outDataA, 304);

      // Flush with simultaneous push and pop while three are stored
      for (int k = 5; k <= 15; k++) begin
         applyStimulus(1'b1, 300 + k, 1'b0, 1'b0);
         @(negedge clock);
      end
      checkOutput("pre_flush_count", countA, 3);
      applyStimulus(1'b1, 316, 1'b1, 1'b1);
      @(negedge clock);
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      checkOutput("flush_count", countA, 0);
      checkOutput("flush_valid", outValidA, 0);
      checkOutput("flush_ovf",   ovfA, 0);

      // Flush alone at phase 2 must restart the phase at 0
      for (int k = 1; k <= 2; k++) begin
         applyStimulus(1'b1, 400 + k, 1'b0, 1'b0);
         @(negedge clock);
      end
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      @(negedge clock);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, 500 + k, 1'b0, 1'b0);
         @(negedge clock);
         checkOutput("phase_clr_count", countA, (k == 4) ? 1 : 0);
      end
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      checkOutput("phase_clr_data", outDataA, 504);
`ifdef FIR_DECIM_OVF_COUNT_EN
      checkOutput("ovfcntA", ovfCntA, 0);
`endif

      // DECIM=1, consumer stalled, 20 samples into a 16-deep FIFO
      for (int i = 1; i <= 20; i++) begin
         validB = 1'b1; sampleB = sample_t'(i);
         @(negedge clock);
         if (i == 16) begin
            checkOutput("fill_count16", countB, 16);
            checkOutput("fill_ovf16",   ovfB, 0);
         end
      end
      validB = 1'b0;
      checkOutput("ovf_count", countB, 16);
      checkOutput("ovf_flag",  ovfB, 1);
      checkOutput("ovf_head",  outDataB, 1);
`ifdef FIR_DECIM_OVF_COUNT_EN
      checkOutput("ovf_cnt", ovfCntB, 4);
`endif
      readyB = 1'b1;
      @(negedge clock);
      readyB = 1'b0;
      checkOutput("ovf_pop_head",  outDataB, 2);
      checkOutput("ovf_pop_count", countB, 15);
      checkOutput("ovf_sticky",    ovfB, 1);
      flushB = 1'b1;
      @(negedge clock);
      flushB = 1'b0;
      checkOutput("flushB_count", countB, 0);
      checkOutput("flushB_ovf",   ovfB, 0);
`ifdef FIR_DECIM_OVF_COUNT_EN
      checkOutput("flushB_cnt", ovfCntB, 0);
`endif

      // Full FIFO with push and pop in the same cycle, negative samples
      for (int k = 1; k <= 16; k++) begin
         validB = 1'b1; sampleB = sample_t'(-k);
         @(negedge clock);
      end
      checkOutput("full_count", countB, 16);
      checkOutput("full_head",  outDataB, -1);
      validB = 1'b1; sampleB = sample_t'(-17); readyB = 1'b1;
      @(negedge clock);
      validB = 1'b0;
      checkOutput("pushpop_count", countB, 16);
      checkOutput("pushpop_ovf",   ovfB, 0);
      for (int k = 2; k <= 17; k++) begin
         checkOutput("drain_data", outDataB, -k);
         @(negedge clock);
      end
      readyB = 1'b0;
      checkOutput("drain_count", countB, 0);
      checkOutput("drain_valid", outValidB, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
